stage1_fetch: RTL and testbench
===============================

// Module: stage1_fetch
// PURPOSE
//  Pipeline stage 1: owns the program counter and issues reads to the instruction memory (1-cycle sync read).
//  Emits {program_counter, instruction, branch_taken_prediction} to decode over Axis, in program order.
//  Holds results in a 2-deep output buffer under back-pressure. Accepts redirects from execute.
//  Optional static branch prediction.
// PARAMETERS
//  WIDTH         32            data/address width
//  RESET_VECTOR  32'h0000_0000 first PC fetched after reset
// PORTS
//  clk                   in   1      clock; only clock
//  rst                   in   1      synchronous reset, active-high
//  redirect_valid        in   1      execute: mispredict/jump, discard everything in flight
//  redirect_address      in   WIDTH  new PC when redirect_valid
//  instruction_port      MemoryInterface.read_out  enable/address out, data (WIDTH) in, 1-cycle latency
//  axis_fetch_to_decode  Axis.out  tvalid, tready; tdata = fetch_to_decode_t
// BEHAVIOUR
//  Reset: pc_q=RESET_VECTOR; tvalid=0, instruction_port.enable=0, inflight/skid valid=0; no issue in the rst cycle.
//  Issue: enable=1, address=pc_q when issue_ok; pc_q<=pc_q+4 (mod 2^WIDTH, wraps silently).
//  Read data belongs to the address issued in the previous cycle; tracked by inflight_valid/inflight_pc.
//  occ = tvalid + skid_valid + inflight_valid; issue_ok = !rst && !redirect_valid && !predict_taken
//    && (occ - (tvalid&&tready)) < 2. Steady state with tready=1: 1 instr/cycle.
//  First tvalid after reset: 2 cycles after rst deasserts (issue cycle 0, data cycle 1, tdata reg cycle 2).
//  Return path: data goes to output reg if (!tvalid || tready) && !skid_valid. Otherwise it goes to skid.
//    Output reg refills from skid before new data. Order is always preserved.
//  Handshake: tdata stable while tvalid && !tready. tready passes straight to ready; no comb path tready->tvalid.
//  Redirect (cycle N): tvalid, skid_valid, inflight_valid <=0 (data arriving at N+1 dropped). pc_q<=redirect_address.
//    No issue at N; redirect_address issued at N+1; its tvalid at N+3. Redirect beats prediction and back-pressure.
//  Redirect during rst: ignored (reset wins).
//  Prediction (returned instr, cycle R): predict_taken when opcode=OP_JAL, or opcode=OP_BRANCH with imm[12]=1.
//    Target = inflight_pc + sign-extended B/J immediate. At R: no issue; pc_q<=target. Instr forwarded with
//    branch_taken_prediction=1. Target issued at R+1: one bubble.
//  Not-taken or other opcodes: branch_taken_prediction=0. JALR is never predicted.
//  Misaligned/ignored addr bits: none; the address is passed through verbatim.
// CONFIGURATION
//  STAGE1_STATIC_PREDICTION_EN defined: prediction as above.
//  Not defined: predict_taken tied 0; branch_taken_prediction always 0; strictly sequential fetch until a redirect.
// STRUCTURE
//  Package (shared): OP_* opcode constants, instruction_undecoded_t (b_type/j_type views), fetch_to_decode_t
//    {program_counter, instruction, branch_taken_prediction}, REGISTER_DEPTH.
//  Sub-module: static_branch_predictor (comb): {instruction, pc} -> {predict_taken, target}.
//    Compiled to constant 0 without the macro.
//  Top holds PC, inflight tracking, output reg + skid register.
// TESTING
//  1. rst 3 cycles, tready=1, imem[i]=NOP -> addresses 0,4,8.. one per cycle; tvalid first at cycle 2; pc in tdata matches.
//  2. tready=0 for 5 cycles mid-stream -> at most 2 words buffered, no issue while full, no loss/dup, order 0x10,0x14,0x18 on release.
//  3. redirect_valid to 0x200 while a word is stalled + one in flight -> both dropped; next tdata pc=0x200, 3 cycles later.
//  4. BEQ at 0x40 with imm=-16 (macro on) -> prediction=1, next pc 0x30 after one bubble. Macro off -> prediction=0, next 0x44.
//  5. JAL at 0x80 imm=+0x100 -> next pc 0x180; BNE forward imm=+8 -> prediction=0, next pc sequential.
//  6. rst asserted mid-stream with tready=0 and redirect_valid=1 -> next cycle tvalid=0, enable=0; restart at RESET_VECTOR.

Source files
------------

// File: rtl/stage1_fetch_pkg.sv
// Shared types for the fetch stage: RISC-V opcode constants, instruction immediate views,
// and the fetch-to-decode payload.
package stage1_fetch_pkg;

  localparam int DATA_WIDTH     = 32;
  // Words the output side can hold: the output register plus the skid register.
  localparam int REGISTER_DEPTH = 2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic       imm_12;
    logic [5:0] imm_10_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [3:0] imm_4_1;
    logic       imm_11;
    logic [6:0] opcode;
  } b_type_t;

  typedef struct packed {
    logic       imm_20;
    logic [9:0] imm_10_1;
    logic       imm_11;
    logic [7:0] imm_19_12;
    logic [4:0] rd;
    logic [6:0] opcode;
  } j_type_t;

  typedef union packed {
    b_type_t b_type;
    j_type_t j_type;
  } instruction_undecoded_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] program_counter;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  branch_taken_prediction;
  } fetch_to_decode_t;

  function automatic logic [DATA_WIDTH-1:0] b_immediate(input instruction_undecoded_t insn);
    return {{19{insn.b_type.imm_12}}, insn.b_type.imm_12, insn.b_type.imm_11,
            insn.b_type.imm_10_5, insn.b_type.imm_4_1, 1'b0};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] j_immediate(input instruction_undecoded_t insn);
    return {{11{insn.j_type.imm_20}}, insn.j_type.imm_20, insn.j_type.imm_19_12,
            insn.j_type.imm_11, insn.j_type.imm_10_1, 1'b0};
  endfunction

endpackage

// File: rtl/stage1_fetch_static_branch_predictor.sv
// Combinational static predictor: JAL and backward conditional branches are predicted taken.
// Active only when STAGE1_STATIC_PREDICTION_EN is defined; otherwise it never predicts.
module stage1_fetch_static_branch_predictor
  import stage1_fetch_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic [WIDTH-1:0]      pc,
  output logic                  predict_taken,
  output logic [WIDTH-1:0]      target
);

`ifdef STAGE1_STATIC_PREDICTION_EN
  instruction_undecoded_t insn;
  logic                   is_jal;
  logic                   is_backward_branch;

  assign insn               = instruction;
  assign is_jal             = insn.j_type.opcode == OP_JAL;
  // A negative offset (imm[12] set) marks a loop back-edge, which is usually taken.
  assign is_backward_branch = (insn.b_type.opcode == OP_BRANCH) && insn.b_type.imm_12;
  assign predict_taken      = is_jal || is_backward_branch;
  assign target             = pc + (is_jal ? j_immediate(insn) : b_immediate(insn));
`else
  logic unused_ok;

  assign unused_ok     = ^{instruction, pc};
  assign predict_taken = 1'b0;
  assign target        = '0;
`endif

endmodule

// File: rtl/stage1_fetch.sv
// Fetch stage: owns the PC, issues 1-cycle instruction memory reads and delivers words in order
// through an output register plus skid register. Prediction enabled by STAGE1_STATIC_PREDICTION_EN.
module stage1_fetch
  import stage1_fetch_pkg::*;
#(
  parameter int               WIDTH        = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_address,
  output logic             instruction_port_enable,
  output logic [WIDTH-1:0] instruction_port_address,
  input  logic [WIDTH-1:0] instruction_port_data,
  output logic             axis_fetch_to_decode_tvalid,
  input  logic             axis_fetch_to_decode_tready,
  output fetch_to_decode_t axis_fetch_to_decode_tdata
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] inflight_pc;
  logic             inflight_valid;
  logic             out_valid;
  logic             skid_valid;
  fetch_to_decode_t out_q;
  fetch_to_decode_t skid_q;
  fetch_to_decode_t returned;

  logic             predict_raw;
  logic             predict_taken;
  logic [WIDTH-1:0] predict_target;
  logic             handshake;
  logic             out_free;
  logic [1:0]       occ;
  logic             issue_ok;
  logic             load_out_from_skid;
  logic             load_out_from_return;
  logic             load_skid;

  stage1_fetch_static_branch_predictor #(
    .WIDTH(WIDTH)
  ) u_predictor (
    .instruction  (instruction_port_data),
    .pc           (inflight_pc),
    .predict_taken(predict_raw),
    .target       (predict_target)
  );

  assign predict_taken = inflight_valid && predict_raw;
  assign handshake     = out_valid && axis_fetch_to_decode_tready;
  assign out_free      = !out_valid || axis_fetch_to_decode_tready;
  assign occ           = 2'(out_valid) + 2'(skid_valid) + 2'(inflight_valid);
  // Only issue when the word would still have a slot once it returns next cycle.
  assign issue_ok      = !rst && !redirect_valid && !predict_taken
                         && ((occ - 2'(handshake)) < 2'(REGISTER_DEPTH));

  assign returned = '{program_counter:         inflight_pc,
                      instruction:             instruction_port_data,
                      branch_taken_prediction: predict_taken};

  // The skid always drains into the output register ahead of newer data, preserving order.
  assign load_out_from_skid   = out_free && skid_valid;
  assign load_out_from_return = out_free && !skid_valid && inflight_valid;
  assign load_skid            = inflight_valid && (skid_valid || !out_free);

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_VECTOR;
      inflight_valid <= 1'b0;
      out_valid      <= 1'b0;
      skid_valid     <= 1'b0;
    end else if (redirect_valid) begin
      pc_q           <= redirect_address;
      inflight_valid <= 1'b0;
      out_valid      <= 1'b0;
      skid_valid     <= 1'b0;
    end else begin
      inflight_valid <= issue_ok;
      if (predict_taken) begin
        pc_q <= predict_target;
      end else if (issue_ok) begin
        pc_q <= pc_q + WIDTH'(4);
      end
      if (out_free) begin
        out_valid  <= skid_valid || inflight_valid;
        skid_valid <= skid_valid && inflight_valid;
      end else begin
        skid_valid <= skid_valid || inflight_valid;
      end
    end
  end

  // NOTE: payload registers carry no reset; their valid bits gate every use.
  always_ff @(posedge clk) begin
    inflight_pc <= pc_q;
    if (load_out_from_skid) begin
      out_q <= skid_q;
    end else if (load_out_from_return) begin
      out_q <= returned;
    end
    if (load_skid) begin
      skid_q <= returned;
    end
  end

  assign instruction_port_enable     = issue_ok;
  assign instruction_port_address    = pc_q;
  assign axis_fetch_to_decode_tvalid = out_valid;
  assign axis_fetch_to_decode_tdata  = out_q;

endmodule

// File: tb/tb_stage1_fetch.sv
// Directed bench for stage1_fetch: program-order stream model checked on every transfer,
// plus hand-computed timing, back-pressure, redirect, prediction and reset expectations.
`timescale 1ns/1ps
module tb_stage1_fetch;
  import stage1_fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;
`ifdef STAGE1_STATIC_PREDICTION_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BEQ_M16  = 32'hFE00_08E3; // beq x0,x0,-16
  localparam logic [31:0] JAL_P256 = 32'h1000_006F; // jal x0,+0x100
  localparam logic [31:0] BNE_P8   = 32'h0000_1463; // bne x0,x0,+8

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             redirect_valid = 1'b0;
  logic [31:0]      redirect_address = '0;
  logic             tready = 1'b0;
  logic             en;
  logic [31:0]      addr;
  logic [31:0]      rdata = '0;
  logic             tvalid;
  fetch_to_decode_t tdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stage1_fetch #(
    .WIDTH(32),
    .RESET_VECTOR(RV)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .redirect_valid             (redirect_valid),
    .redirect_address           (redirect_address),
    .instruction_port_enable    (en),
    .instruction_port_address   (addr),
    .instruction_port_data      (rdata),
    .axis_fetch_to_decode_tvalid(tvalid),
    .axis_fetch_to_decode_tready(tready),
    .axis_fetch_to_decode_tdata (tdata)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0040: return BEQ_M16;
      32'h0000_0080: return JAL_P256;
      32'h0000_0180: return BNE_P8;
      default:       return NOP;
    endcase
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) if (en) rdata <= imem_word(addr);

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Program-order model: which word must follow which, from the ISA rules alone.
  function automatic bit model_taken(input logic [31:0] i);
    return PRED_EN && ((i[6:0] == 7'h6F) || ((i[6:0] == 7'h63) && i[31]));
  endfunction

  function automatic logic [31:0] model_offset(input logic [31:0] i);
    if (i[6:0] == 7'h6F) return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  logic [31:0]      model_pc = RV;
  logic [31:0]      exp_instr;
  logic             prev_stall = 1'b0;
  fetch_to_decode_t prev_data;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        model_pc   = RV;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(tvalid), 32'd1);
          check("hold_pc", tdata.program_counter, prev_data.program_counter);
          check("hold_instr", tdata.instruction, prev_data.instruction);
        end
        if (tvalid && tready) begin
          exp_instr = imem_word(model_pc);
          check("stream_pc", tdata.program_counter, model_pc);
          check("stream_instr", tdata.instruction, exp_instr);
          check("stream_pred", 32'(tdata.branch_taken_prediction), 32'(model_taken(exp_instr)));
          model_pc = model_taken(exp_instr) ? model_pc + model_offset(exp_instr) : model_pc + 32'd4;
        end
        prev_stall = tvalid && !tready && !redirect_valid;
        prev_data  = tdata;
        if (redirect_valid) model_pc = redirect_address;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [31:0] pc, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tvalid && tready && tdata.program_counter == pc) && n < 40);
    check(name, tvalid ? tdata.program_counter : 32'hDEAD_BEEF, pc);
  endtask

  task automatic next_word(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!tvalid && gap < 20);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    cycle();
    redirect_valid   = 1'b1;
    redirect_address = a;
    cycle();
    redirect_valid   = 1'b0;
  endtask

  int gap;

  initial begin
    tready = 1'b1;
    // Reset held for three cycles.
    @(negedge clk);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_enable", 32'(en), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Startup timing: issue in cycle 0, first word valid in cycle 2.
    @(negedge clk);
    check("c0_enable", 32'(en), 32'd1);
    check("c0_address", addr, RV);
    check("c0_tvalid", 32'(tvalid), 32'd0);
    @(negedge clk);
    check("c1_address", addr, RV + 32'd4);
    check("c1_tvalid", 32'(tvalid), 32'd0);
    @(negedge clk);
    check("c2_tvalid", 32'(tvalid), 32'd1);
    check("c2_pc", tdata.program_counter, RV);

    // Back-pressure: five stalled cycles, nothing issued once both slots are committed.
    wait_pc(32'h0C, "pre_stall_0x0c");
    cycle();
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_no_issue", 32'(en), 32'd0);
      check("stall_head_pc", tdata.program_counter, 32'h10);
    end
    cycle();
    tready = 1'b1;
    wait_pc(32'h10, "release_0x10");
    @(negedge clk);
    check("release_0x14", tvalid ? tdata.program_counter : 32'hDEAD_BEEF, 32'h14);
    @(negedge clk);
    check("release_0x18", tvalid ? tdata.program_counter : 32'hDEAD_BEEF, 32'h18);

    // Redirect with one word stalled and one in flight: both dropped, 0x200 three cycles later.
    wait_pc(32'h20, "pre_redirect_0x20");
    cycle();
    tready           = 1'b0;
    redirect_valid   = 1'b1;
    redirect_address = 32'h200;
    @(negedge clk);
    check("redir_stalled_pc", tdata.program_counter, 32'h24);
    cycle();
    tready         = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_flush_tvalid", 32'(tvalid), 32'd0);
    next_word(gap);
    check("redir_latency", 32'(gap + 1), 32'd3);
    check("redir_pc", tdata.program_counter, 32'h200);

    // PC wraps silently at the top of the address space.
    redirect_to(32'hFFFF_FFF8);
    wait_pc(32'hFFFF_FFF8, "wrap_start");
    next_word(gap);
    check("wrap_fffffffc", tdata.program_counter, 32'hFFFF_FFFC);
    next_word(gap);
    check("wrap_zero", tdata.program_counter, 32'h0);

    // Backward BEQ at 0x40.
    redirect_to(32'h38);
    wait_pc(32'h40, "beq_seen");
    check("beq_pred", 32'(tdata.branch_taken_prediction), 32'(PRED_EN));
    next_word(gap);
    check("beq_gap", 32'(gap), PRED_EN ? 32'd2 : 32'd1);
    check("beq_next_pc", tdata.program_counter, PRED_EN ? 32'h30 : 32'h44);

    // JAL at 0x80, then forward BNE at 0x180.
    redirect_to(32'h80);
    wait_pc(32'h80, "jal_seen");
    check("jal_pred", 32'(tdata.branch_taken_prediction), 32'(PRED_EN));
    next_word(gap);
    check("jal_gap", 32'(gap), PRED_EN ? 32'd2 : 32'd1);
    check("jal_next_pc", tdata.program_counter, PRED_EN ? 32'h180 : 32'h84);
    redirect_to(32'h17C);
    wait_pc(32'h180, "bne_seen");
    check("bne_pred", 32'(tdata.branch_taken_prediction), 32'd0);
    next_word(gap);
    check("bne_gap", 32'(gap), 32'd1);
    check("bne_next_pc", tdata.program_counter, 32'h184);

    // Reset beats a simultaneous redirect and back-pressure.
    cycle();
    tready           = 1'b0;
    redirect_valid   = 1'b1;
    redirect_address = 32'h300;
    rst              = 1'b1;
    @(negedge clk);
    check("rst_mid_enable", 32'(en), 32'd0);
    cycle();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    tready         = 1'b1;
    @(negedge clk);
    check("rst_mid_tvalid", 32'(tvalid), 32'd0);
    check("rst_mid_restart_addr", addr, RV);
    next_word(gap);
    check("rst_mid_latency", 32'(gap), 32'd2);
    check("rst_mid_pc", tdata.program_counter, RV);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
